an_tile_packer_n29: RTL and testbench
=====================================

# an_tile_packer_n29

Streaming AN-code encoder and 6x6 tile assembler that sits directly upstream of the 6x6 A=29 Barrett/AN-decoder array. It accepts 10-bit messages one per cycle over a valid/ready handshake and encodes each as codeword = 29·m. It packs the codewords row-major into double-buffered 36-element tiles and presents each completed tile, with its 36 codewords in parallel, to the decoder array's IN0..IN35. An optional single-element fault-injection path supports the error-correction experiments.

## Interface
- A, 29, AN-code multiplier (fixed to 29 for this instance)
- N, 6, tile dimension; tile holds N·N = 36 elements
- MSG_W, 10, message width
- CW_W, 14, codeword width
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  message present
- in_ready  out  1  packer can accept a message
- in_msg  in  MSG_W  message
- flush  in  1  close the partially filled tile (single-cycle pulse)
- inj_en  in  1  arm fault injection for the next accepted message
- inj_mask  in  CW_W  XOR mask applied to that message's codeword
- tile_valid  out  1  a complete tile is presented
- tile_ready  in  1  downstream consumes the tile
- tile_cw  out  N·N·CW_W  element k occupies bits [k·CW_W +: CW_W]; k = 6·row + col, which maps to decoder input INk
- tile_level  out  6  number of written elements in the presented tile (1..36)
- range_err  out  1  sticky flag: a message above MSG_MAX was seen
- tile_cnt  out  16  tiles handed off, wraps modulo 2^16

## Operation
- MSG_MAX = floor((2^CW_W − 1)/A) = 564. Messages above 564 are clamped to 564 before encoding and set range_err.
- Encoding is shift-add only: cw = (m<<4)+(m<<3)+(m<<2)+m, computed at 15 bits and always ≤ 16356 after the clamp.
- Injection: if inj_en is high on an accept cycle, the stored codeword is cw ^ inj_mask. inj_en has no effect on cycles without an accept.
- Two banks, B0 and B1. Each bank is in one of three states: EMPTY, FILLING or FULL.
  - The write bank moves from EMPTY to FILLING on its first accept.
  - It moves from FILLING to FULL on the 36th accept, or on flush when its level is at least 1. The write pointer then toggles.
- The read bank is the oldest FULL bank. It moves from FULL to EMPTY on a tile handshake (tile_valid & tile_ready), and tile_cnt increments on that handshake.
- in_ready = 1 unless both banks are FULL.
- Accept = in_valid & in_ready. The message is written at index = level, and level increments.
- Elements at index ≥ tile_level read as 0 in tile_cw. Codeword 0 is valid, so no false error is raised downstream.
- Flush with level = 0 is ignored.
- Flush on the same cycle as an accept: the message is written first, then the bank closes. If that accept is the 36th element, the tile closes normally and only one tile results.
- Tile handshake on the same cycle as an accept into the other bank: both take effect.

## Timing
- Reset values: in_ready=1, tile_valid=0, tile_cw=0, tile_level=0, range_err=0, tile_cnt=0. Both banks are EMPTY and the write pointer selects B0.
- Reset mid-fill or mid-presentation discards all tile contents. No partial tile is ever emitted.
- Latency: tile_valid rises on the cycle after the closing accept or flush.
- tile_cw and tile_level are registered and stay stable while tile_valid=1 && tile_ready=0.
- Throughput: 1 message per cycle is sustained indefinitely when tile_ready is high at least 1 cycle in every 36.
- in_ready falls on the cycle after the 72nd un-drained accept. It rises on the cycle after the next tile handshake.

## Structure
- The shared package an_n29_pkg holds A, N, MSG_W, CW_W, MSG_MAX and the bank-state enum (EMPTY/FILLING/FULL). The decoder array uses the same constants.
- One sub-module: an_encode_n29, a combinational clamp, shift-add encode and injection XOR, reusable in other benches.
- Bank storage is 2×36×14 flops, not RAM, because all 36 elements are read in parallel.

## Test plan
- Messages 0..35 back-to-back with tile_ready=1 → tile_valid on the cycle after the 36th accept. Element k = 29k (element 35 = 1015), tile_level=36, tile_cnt=1.
- Messages 564, 565, 1023 → codewords 16356, 16356, 16356 and range_err=1. range_err holds until rst.
- tile_ready=0 while 80 messages are offered → in_ready=0 after 72 accepts and the 73rd is stalled. Raising tile_ready → tile 1 then tile 2 in order, and the 73rd is accepted.
- 7 messages of value 100, then flush → tile_level=7, elements 0..6 = 2900, elements 7..35 = 0. The next message starts a new tile at index 0.
- inj_en=1 with inj_mask=14'h0001 on the 15th message (value 10) → element 14 = 291, all others nominal. Feeding this tile to the decoder array makes OUT14 = 10.
- rst pulsed after 20 accepts with tile_ready=0 → no tile_valid afterwards. The next 36 messages form a clean tile and tile_cnt=1 after its handshake.

Source files
------------

// File: rtl/an_n29_pkg.sv
// Shared constants and types for the A=29 AN-code tile packer and decoder array.
// Codeword width, tile geometry and the bank state encoding live here.
package an_n29_pkg;

    localparam int A       = 29;
    localparam int N       = 6;
    localparam int NE      = N * N;
    localparam int MSG_W   = 10;
    localparam int CW_W    = 14;
    localparam int LVL_W   = 6;
    localparam int CNT_W   = 16;
    localparam int MSG_MAX = ((1 << CW_W) - 1) / A;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_st_e;

endpackage

// File: rtl/an_encode_n29.sv
// Combinational clamp, shift-add AN encode (x29) and optional fault XOR.
// Reusable stand-alone so other benches can build reference codewords.
module an_encode_n29
    import an_n29_pkg::*;
(
    input  logic [MSG_W-1:0] msg,
    input  logic             inj_en,
    input  logic [CW_W-1:0]  inj_mask,
    output logic [CW_W-1:0]  cw,
    output logic             over
);

    localparam int PW = CW_W + 1;

    logic [MSG_W-1:0] m;
    logic [PW-1:0]    mw;
    logic [PW-1:0]    prod;
    logic [CW_W-1:0]  base;

    assign over = (msg > MSG_W'(MSG_MAX));
    assign m    = over ? MSG_W'(MSG_MAX) : msg;
    assign mw   = PW'(m);

    // 29 = 16 + 8 + 4 + 1
    assign prod = (mw << 4) + (mw << 3) + (mw << 2) + mw;

    // The clamp keeps prod below 2^CW_W; saturate defensively anyway.
    assign base = prod[CW_W] ? '1 : prod[CW_W-1:0];
    assign cw   = base ^ (inj_en ? inj_mask : '0);

endmodule

// File: rtl/an_tile_packer_n29.sv
// Streaming AN encoder feeding two ping-pong 6x6 tile banks.
// Each completed tile is presented with all 36 codewords in parallel.
module an_tile_packer_n29
    import an_n29_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [MSG_W-1:0]       in_msg,
    input  logic                   flush,
    input  logic                   inj_en,
    input  logic [CW_W-1:0]        inj_mask,
    output logic                   tile_valid,
    input  logic                   tile_ready,
    output logic [NE*CW_W-1:0]     tile_cw,
    output logic [LVL_W-1:0]       tile_level,
    output logic                   range_err,
    output logic [CNT_W-1:0]       tile_cnt
);

    bank_st_e         st_q  [2];
    bank_st_e         st_d  [2];
    logic [LVL_W-1:0] lvl_q [2];
    logic [LVL_W-1:0] lvl_d [2];
    logic             wr_q, wr_d;
    logic             rd_q, rd_d;

    logic [CW_W-1:0]  mem [2][NE];

    logic             accept;
    logic             hs;
    logic [CW_W-1:0]  enc_cw;
    logic             enc_over;
    logic [LVL_W-1:0] wr_lvl_nx;
    logic [LVL_W-1:0] rd_lvl;

    an_encode_n29 u_enc (
        .msg      (in_msg),
        .inj_en   (inj_en),
        .inj_mask (inj_mask),
        .cw       (enc_cw),
        .over     (enc_over)
    );

    assign accept = in_valid & in_ready;
    assign hs     = tile_valid & tile_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            st_q[0]   <= EMPTY;
            st_q[1]   <= EMPTY;
            lvl_q[0]  <= '0;
            lvl_q[1]  <= '0;
            wr_q      <= 1'b0;
            rd_q      <= 1'b0;
            range_err <= 1'b0;
            tile_cnt  <= '0;
        end else begin
            st_q[0]   <= st_d[0];
            st_q[1]   <= st_d[1];
            lvl_q[0]  <= lvl_d[0];
            lvl_q[1]  <= lvl_d[1];
            wr_q      <= wr_d;
            rd_q      <= rd_d;
            if (accept && enc_over)
                range_err <= 1'b1;
            if (hs)
                tile_cnt <= tile_cnt + 1'b1;
        end
    end

    // Element storage needs no reset: stale entries sit at or above the level.
    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_q][lvl_q[wr_q]] <= enc_cw;
    end

    // Next-state logic
    always_comb begin
        st_d[0]   = st_q[0];
        st_d[1]   = st_q[1];
        lvl_d[0]  = lvl_q[0];
        lvl_d[1]  = lvl_q[1];
        wr_d      = wr_q;
        rd_d      = rd_q;
        wr_lvl_nx = lvl_q[wr_q] + LVL_W'(accept);

        if (hs) begin
            st_d[rd_q]  = EMPTY;
            lvl_d[rd_q] = '0;
            rd_d        = ~rd_q;
        end

        // A non-FULL write bank is never the bank being drained.
        if (st_q[wr_q] != FULL) begin
            if (accept) begin
                lvl_d[wr_q] = wr_lvl_nx;
                st_d[wr_q]  = FILLING;
            end
            if (wr_lvl_nx == LVL_W'(NE) ||
                (flush && wr_lvl_nx != '0)) begin
                st_d[wr_q] = FULL;
                wr_d       = ~wr_q;
            end
        end
    end

    // Output logic
    always_comb begin
        in_ready   = !(st_q[0] == FULL && st_q[1] == FULL);
        tile_valid = (st_q[rd_q] == FULL);
        rd_lvl     = lvl_q[rd_q];
        tile_level = tile_valid ? rd_lvl : '0;
        tile_cw    = '0;
        for (int k = 0; k < NE; k++) begin
            if (tile_valid && LVL_W'(k) < rd_lvl)
                tile_cw[k*CW_W +: CW_W] = mem[rd_q][k];
        end
    end

endmodule

// File: tb/tb_an_tile_packer_n29.sv
// Scoreboard bench for an_tile_packer_n29: directed test-plan cases
// followed by random traffic, checked against a list-based tile model.
module tb_an_tile_packer_n29;
    import an_n29_pkg::*;

    localparam int TW = NE * CW_W;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [MSG_W-1:0] in_msg = '0;
    logic             flush = 1'b0;
    logic             inj_en = 1'b0;
    logic [CW_W-1:0]  inj_mask = '0;
    logic             tile_valid;
    logic             tile_ready = 1'b0;
    logic [TW-1:0]    tile_cw;
    logic [LVL_W-1:0] tile_level;
    logic             range_err;
    logic [CNT_W-1:0] tile_cnt;

    an_tile_packer_n29 dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_msg     (in_msg),
        .flush      (flush),
        .inj_en     (inj_en),
        .inj_mask   (inj_mask),
        .tile_valid (tile_valid),
        .tile_ready (tile_ready),
        .tile_cw    (tile_cw),
        .tile_level (tile_level),
        .range_err  (range_err),
        .tile_cnt   (tile_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0] cw;
        int            lvl;
    } tile_t;

    tile_t exp_q[$];
    int    cur[$];
    int    closed   = 0;
    int    drained  = 0;
    int    pend_now = 0;
    bit    exp_rng  = 1'b0;
    bit    in_rst   = 1'b1;
    int    checks   = 0;
    int    errors   = 0;

    task automatic chk(input string nm, input logic [TW-1:0] got,
                       input logic [TW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", nm, got, exp);
        end
    endtask

    function automatic int ref_cw(input int m, input bit ij, input int mk);
        int mc;
        mc = (m > MSG_MAX) ? MSG_MAX : m;
        return (A * mc) ^ (ij ? mk : 0);
    endfunction

    // One clock of stimulus; the model decides whether it is accepted.
    task automatic cyc(input bit v, input int m, input bit fl,
                       input bit ij, input int mk, input bit tr,
                       output bit acc);
        tile_t t;
        @(negedge clk);
        in_valid   = v;
        in_msg     = MSG_W'(m);
        flush      = fl;
        inj_en     = ij;
        inj_mask   = CW_W'(mk);
        tile_ready = tr;
        #1;
        pend_now = closed - drained;
        chk("in_ready", TW'(in_ready), TW'(pend_now < 2));
        chk("range_err", TW'(range_err), TW'(exp_rng));
        acc = v && (pend_now < 2);
        if (acc) begin
            if (m > MSG_MAX) exp_rng = 1'b1;
            cur.push_back(ref_cw(m, ij, mk));
        end
        if (pend_now < 2 &&
            (cur.size() == NE || (fl && cur.size() > 0))) begin
            t.cw  = '0;
            t.lvl = cur.size();
            foreach (cur[k]) t.cw[k*CW_W +: CW_W] = CW_W'(cur[k]);
            exp_q.push_back(t);
            cur.delete();
            closed++;
        end
    endtask

    task automatic idle(input bit tr);
        bit a;
        cyc(1'b0, 0, 1'b0, 1'b0, 0, tr, a);
    endtask

    task automatic send(input int m, input bit tr);
        bit a;
        cyc(1'b1, m, 1'b0, 1'b0, 0, tr, a);
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_rst   = 1'b1;
        rst      = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        inj_en   = 1'b0;
        tile_ready = 1'b0;
        exp_q.delete();
        cur.delete();
        closed   = 0;
        drained  = 0;
        pend_now = 0;
        exp_rng  = 1'b0;
        @(negedge clk);
        rst    = 1'b0;
        in_rst = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((closed - drained) > 0 && n < 200) begin
            idle(1'b1);
            n++;
        end
        chk("drain_timeout", TW'(closed - drained), TW'(0));
    endtask

    // Monitor: pops the oldest expected tile on every handshake.
    always @(negedge clk) begin
        tile_t t;
        #2;
        if (!in_rst) begin
            chk("tile_valid", TW'(tile_valid), TW'(pend_now > 0));
            chk("tile_cnt", TW'(tile_cnt), TW'(CNT_W'(drained)));
            if (tile_valid && tile_ready) begin
                if (exp_q.size() == 0) begin
                    chk("tile_unexpected", TW'(1), TW'(0));
                end else begin
                    t = exp_q.pop_front();
                    chk("tile_cw", tile_cw, t.cw);
                    chk("tile_level", TW'(tile_level), TW'(t.lvl));
                end
                drained++;
            end
        end
    end

    initial begin
        bit a;
        int n;
        int guard;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", TW'(in_ready), TW'(1));
        chk("rst_tile_valid", TW'(tile_valid), TW'(0));
        chk("rst_tile_cw", tile_cw, TW'(0));
        chk("rst_tile_level", TW'(tile_level), TW'(0));
        chk("rst_range_err", TW'(range_err), TW'(0));
        chk("rst_tile_cnt", TW'(tile_cnt), TW'(0));
        in_rst = 1'b0;

        // Back-to-back 0..35
        for (int i = 0; i < NE; i++) send(i, 1'b1);
        drain();

        // Clamp and sticky range error, then flush
        send(564, 1'b1);
        send(565, 1'b1);
        send(1023, 1'b1);
        cyc(1'b0, 0, 1'b1, 1'b0, 0, 1'b1, a);
        drain();
        idle(1'b1);
        idle(1'b1);

        // Backpressure: 80 offered with tile_ready low, 72 taken
        n = 0;
        for (int c = 0; c < 80; c++) begin
            cyc(1'b1, n % 1024, 1'b0, 1'b0, 0, 1'b0, a);
            if (a) n++;
        end
        chk("stall_accepts", TW'(n), TW'(72));
        guard = 0;
        while (n < 80 && guard < 200) begin
            cyc(1'b1, n % 1024, 1'b0, 1'b0, 0, 1'b1, a);
            if (a) n++;
            guard++;
        end
        cyc(1'b0, 0, 1'b1, 1'b0, 0, 1'b1, a);
        drain();

        // Partial tile by flush, then a fresh tile
        for (int i = 0; i < 7; i++) send(100, 1'b1);
        cyc(1'b0, 0, 1'b1, 1'b0, 0, 1'b1, a);
        for (int i = 0; i < 4; i++) send(i + 1, 1'b1);
        cyc(1'b1, 9, 1'b1, 1'b0, 0, 1'b1, a);
        drain();

        // Flush coinciding with the 36th accept yields one tile
        for (int i = 0; i < NE - 1; i++) send(i * 3, 1'b1);
        cyc(1'b1, 7, 1'b1, 1'b0, 0, 1'b1, a);
        cyc(1'b0, 0, 1'b1, 1'b0, 0, 1'b1, a);
        drain();

        // Fault injection on element 14
        for (int i = 0; i < NE; i++)
            cyc(1'b1, (i == 14) ? 10 : i, 1'b0, (i == 14), 1, 1'b1, a);
        drain();

        // Reset mid-fill discards everything
        for (int i = 0; i < 20; i++) send(i + 50, 1'b0);
        do_reset();
        for (int i = 0; i < 5; i++) idle(1'b1);
        for (int i = 0; i < NE; i++) send(i + 200, 1'b1);
        drain();
        chk("post_rst_tile_cnt", TW'(tile_cnt), TW'(1));

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            cyc(($urandom % 4) != 0, int'($urandom % 1024),
                ($urandom % 25) == 0, ($urandom % 10) == 0,
                int'($urandom % (1 << CW_W)),
                ($urandom % 10) < 6, a);
        end
        cyc(1'b0, 0, 1'b1, 1'b0, 0, 1'b1, a);
        drain();
        idle(1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
